audio_mixer_n: RTL and testbench

Parametrised N-channel audio mixer for the `emu` top level. It replaces the fixed three-source sum-and-clip path (OPLL + PSG + PCM) with per-channel gain, unsigned/signed input handling, a serial multiply-accumulate and saturating output. It sits between the core's sound generators and `AUDIO_L`/`AUDIO_R`, clocked on `clk_sys` and paced by a sample strobe.

---
 rtl/audio_mixer_n_pkg.sv | 12 +
 rtl/audio_mixer_n_if.sv | 19 +
 rtl/audio_mixer_n_dc_block.sv | 35 +++
 rtl/audio_mixer_n.sv | 115 +++++++++++
 tb/tb_audio_mixer_n.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/audio_mixer_n_pkg.sv
// audio_mix_pkg: shared FSM states, gain scaling and the signed clamp helper for audio_mixer_n.
package audio_mix_pkg;
    typedef enum logic [1:0] {IDLE, ACC, SAT, DCB} mix_state_t;
    localparam int GAIN_UNITY = 8;
    localparam int GAIN_SHIFT = $clog2(GAIN_UNITY);
    function automatic logic signed [63:0] sat_s(input logic signed [63:0] value, input int width);
        logic signed [63:0] hi, lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        return (value > hi) ? hi : (value < lo) ? lo : value;
    endfunction
endpackage

// File: rtl/audio_mixer_n_if.sv
// audio_mixer_n_if: sample strobe, channel inputs and mixed-output signals of audio_mixer_n.
interface audio_mixer_n_if #(
    parameter int NCH = 4,
    parameter int IW  = 16,
    parameter int OW  = 16,
    parameter int GW  = 4
) ();
    logic              ce_sample;
    logic [NCH*IW-1:0] in_data;
    logic [NCH-1:0]    in_signed;
    logic [NCH*GW-1:0] gain;
    logic              mute;
    logic [OW-1:0]     out_data;
    logic              out_valid;
    logic              busy;
    logic              overrun;
    modport master (output ce_sample, in_data, in_signed, gain, mute, input out_data, out_valid, busy, overrun);
    modport slave (input ce_sample, in_data, in_signed, gain, mute, output out_data, out_valid, busy, overrun);
endinterface

// File: rtl/audio_mixer_n_dc_block.sv
// audio_dc_block: one-pole DC blocker y = x - x_prev + y_prev - (y_prev >>> 10), saturated to OW bits.
module audio_dc_block import audio_mix_pkg::*; #(
    parameter int OW = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en_i,
    input  logic signed [OW-1:0] x_i,
    output logic signed [OW-1:0] y_o,
    output logic                 valid_o
);
    localparam int YW = OW + 3;
    logic signed [OW-1:0] xp_q, yp_q, y_d;
    logic                 valid_q;
    logic signed [YW-1:0] y_raw;
    always_comb begin
        y_raw = YW'(x_i) - YW'(xp_q) + YW'(yp_q) - YW'(yp_q >>> 10);
        y_d   = OW'(sat_s(64'(y_raw), OW));
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xp_q    <= '0;
            yp_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= en_i;
            if (en_i) begin
                xp_q <= x_i;
                yp_q <= y_d;
            end
        end
    end
    assign y_o     = yp_q;
    assign valid_o = valid_q;
endmodule

// File: rtl/audio_mixer_n.sv
// audio_mixer_n: N-channel gain/sum/saturate mixer with a serial MAC, one channel per cycle.
// Optional DC blocker after saturation when AUDIO_MIXER_DC_BLOCK_EN is defined.
module audio_mixer_n import audio_mix_pkg::*; #(
    parameter int NCH = 4,
    parameter int IW  = 16,
    parameter int OW  = 16,
    parameter int GW  = 4
) (
    input logic clk_sys,
    input logic reset,
    audio_mixer_n_if.slave bus
);
    localparam int AW = IW + GW + 1 + $clog2(NCH);
    localparam int XW = (NCH > 1) ? $clog2(NCH) : 1;
`ifdef AUDIO_MIXER_DC_BLOCK_EN
    localparam mix_state_t SAT_NEXT = DCB;
`else
    localparam mix_state_t SAT_NEXT = IDLE;
`endif
    mix_state_t           state_q, state_d;
    logic [XW-1:0]        idx_q, idx_d;
    logic signed [AW-1:0] acc_q, acc_d, prod, acc_sum;
    logic [NCH*IW-1:0]    data_q, data_d;
    logic [NCH-1:0]       sgn_q, sgn_d;
    logic [NCH*GW-1:0]    gain_q, gain_d;
    logic                 mute_q, mute_d;
    logic [OW-1:0]        out_q, out_d;
    logic                 valid_q, valid_d, ovr_q, ovr_d, last;
    logic [IW-1:0]        raw;
    logic signed [IW-1:0] s;
    logic [GW-1:0]        g;
    logic signed [63:0]   clamp;
    always_comb begin
        raw     = data_q[idx_q*IW +: IW];
        s       = {raw[IW-1] ^ ~sgn_q[idx_q], raw[IW-2:0]};
        g       = gain_q[idx_q*GW +: GW];
        prod    = AW'(s) * AW'($signed({1'b0, g}));
        acc_sum = acc_q + prod;
        clamp   = sat_s(64'(acc_sum >>> GAIN_SHIFT), IW);
        last    = idx_q == XW'(NCH - 1);
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        data_d  = data_q;
        sgn_d   = sgn_q;
        gain_d  = gain_q;
        mute_d  = mute_q;
        out_d   = out_q;
        valid_d = 1'b0;
        ovr_d   = bus.ce_sample && state_q != IDLE;
        case (state_q)
            IDLE: if (bus.ce_sample) begin
                data_d  = bus.in_data;
                sgn_d   = bus.in_signed;
                gain_d  = bus.gain;
                mute_d  = bus.mute;
                acc_d   = '0;
                idx_d   = '0;
                state_d = ACC;
            end
            ACC: begin
                acc_d = acc_sum;
                idx_d = idx_q + XW'(1);
                // The final product is folded straight into the result so out_valid lands in SAT.
                if (last) begin
                    state_d = SAT;
                    out_d   = mute_q ? '0 : clamp[IW-1 -: OW];
                    valid_d = 1'b1;
                end
            end
            SAT: state_d = SAT_NEXT;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            acc_q   <= '0;
            data_q  <= '0;
            sgn_q   <= '0;
            gain_q  <= '0;
            mute_q  <= 1'b0;
            out_q   <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            data_q  <= data_d;
            sgn_q   <= sgn_d;
            gain_q  <= gain_d;
            mute_q  <= mute_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end
    assign bus.busy    = state_q != IDLE;
    assign bus.overrun = ovr_q;
`ifdef AUDIO_MIXER_DC_BLOCK_EN
    audio_dc_block #(.OW(OW)) u_dcb (
        .clk     (clk_sys),
        .rst     (reset),
        .en_i    (valid_q),
        .x_i     (out_q),
        .y_o     (bus.out_data),
        .valid_o (bus.out_valid)
    );
`else
    assign bus.out_data  = out_q;
    assign bus.out_valid = valid_q;
`endif
endmodule

// File: tb/tb_audio_mixer_n.sv
// tb_audio_mixer_n: directed and random mixes of audio_mixer_n against an arithmetic reference model.
module tb_audio_mixer_n;
    localparam int NCH = 4;
    localparam int IW  = 16;
    localparam int OW  = 16;
    localparam int GW  = 4;
`ifdef AUDIO_MIXER_DC_BLOCK_EN
    localparam int LAT = NCH + 2;
`else
    localparam int LAT = NCH + 1;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    audio_mixer_n_if #(.NCH(NCH), .IW(IW), .OW(OW), .GW(GW)) bus ();
    audio_mixer_n #(.NCH(NCH), .IW(IW), .OW(OW), .GW(GW)) dut (
        .clk_sys (clk),
        .reset   (rst),
        .bus     (bus)
    );
    int n_chk = 0;
    int n_fail = 0;
    int n_valid = 0;
    int n_ovr = 0;
    longint xp = 0;
    longint yp = 0;
    logic [OW-1:0] last_y;
    always @(negedge clk) begin
        if (bus.out_valid === 1'b1) n_valid <= n_valid + 1;
        if (bus.overrun === 1'b1) n_ovr <= n_ovr + 1;
    end
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    function automatic longint clip(input longint v, input int w);
        longint hi = (longint'(1) << (w - 1)) - 1;
        return (v > hi) ? hi : (v < -hi - 1) ? -hi - 1 : v;
    endfunction
    // Offset-binary samples are the raw code minus half scale; gain is in eighths.
    function automatic longint mix_x(input logic [NCH*IW-1:0] d, input logic [NCH-1:0] sg,
                                     input logic [NCH*GW-1:0] g, input logic m);
        longint sum = 0;
        longint smp;
        logic [IW-1:0] w;
        for (int k = 0; k < NCH; k++) begin
            w = d[k*IW +: IW];
            smp = sg[k] ? longint'($signed(w)) : longint'(w) - (longint'(1) << (IW - 1));
            sum += smp * longint'(g[k*GW +: GW]);
        end
        return m ? 0 : (clip(sum >>> 3, IW) >>> (IW - OW));
    endfunction
    task automatic scramble();
        bus.in_data   = {$urandom, $urandom};
        bus.in_signed = NCH'($urandom);
        bus.gain      = (NCH*GW)'($urandom);
        bus.mute      = 1'($urandom);
    endtask
    task automatic run_mix(input logic [NCH*IW-1:0] d, input logic [NCH-1:0] sg,
                           input logic [NCH*GW-1:0] g, input logic m, input int s2, input string tag);
        longint x, y;
        int lat;
        logic [OW-1:0] got, e;
        x = mix_x(d, sg, g, m);
`ifdef AUDIO_MIXER_DC_BLOCK_EN
        y = clip(x - xp + yp - (yp >>> 10), OW);
        xp = x;
        yp = y;
`else
        y = x;
`endif
        e = OW'(y);
        bus.in_data = d;
        bus.in_signed = sg;
        bus.gain = g;
        bus.mute = m;
        bus.ce_sample = 1'b1;
        @(posedge clk); #1;
        lat = 0;
        got = '0;
        for (int n = 1; n <= LAT; n++) begin
            scramble();
            bus.ce_sample = (n == s2);
            @(negedge clk);
            if (n == 1) check({tag, " busy"}, 64'(bus.busy), 64'd1);
            if (bus.out_valid === 1'b1 && lat == 0) begin
                lat = n;
                got = bus.out_data;
            end
            @(posedge clk); #1;
        end
        bus.ce_sample = 1'b0;
        check({tag, " latency"}, 64'(lat), 64'(LAT));
        check({tag, " data"}, 64'(got), 64'(e));
        last_y = got;
    endtask
    task automatic check_idle_outputs(input string tag);
        check({tag, " out_data"}, 64'(bus.out_data), 64'd0);
        check({tag, " out_valid"}, 64'(bus.out_valid), 64'd0);
        check({tag, " busy"}, 64'(bus.busy), 64'd0);
        check({tag, " overrun"}, 64'(bus.overrun), 64'd0);
    endtask
    initial begin
        int v0, o0;
        bus.ce_sample = 1'b0;
        bus.in_data = '0;
        bus.in_signed = '0;
        bus.gain = '0;
        bus.mute = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_mix({16'h0000, 16'h0000, 16'h8000, 16'h1000}, 4'b1101, 16'h8888, 1'b0, 0, "unity");
        run_mix({4{16'h7000}}, 4'b1111, 16'hFFFF, 1'b0, 0, "clip_pos");
        run_mix({4{16'h9000}}, 4'b1111, 16'hFFFF, 1'b0, 0, "clip_neg");
        run_mix({16'h0000, 16'h2000, 16'h0000, 16'h0000}, 4'b1111, 16'h8488, 1'b0, 0, "gain4");
        run_mix({16'h0000, 16'h2000, 16'h0000, 16'h0000}, 4'b1111, 16'h8488, 1'b1, 0, "mute");
        v0 = n_valid;
        o0 = n_ovr;
        run_mix({16'h0123, 16'h0456, 16'h0789, 16'h0ABC}, 4'b1111, 16'h3579, 1'b0, 3, "ovr3");
        repeat (2) @(posedge clk); #1;
        check("ovr3 overrun count", 64'(n_ovr - o0), 64'd1);
        check("ovr3 valid count", 64'(n_valid - v0), 64'd1);
        v0 = n_valid;
        o0 = n_ovr;
        run_mix({16'h1111, 16'h2222, 16'h3333, 16'h4444}, 4'b1010, 16'h1234, 1'b0, 0, "spaced_a");
        run_mix({16'hF000, 16'h0F00, 16'h00F0, 16'h000F}, 4'b0101, 16'hFEDC, 1'b0, 0, "spaced_b");
        repeat (2) @(posedge clk); #1;
        check("spaced overrun count", 64'(n_ovr - o0), 64'd0);
        check("spaced valid count", 64'(n_valid - v0), 64'd2);
        v0 = n_valid;
        o0 = n_ovr;
        run_mix({16'h0000, 16'h0000, 16'h0000, 16'h3000}, 4'b1111, 16'h8888, 1'b0, LAT, "ovr_at_valid");
        repeat (2) @(posedge clk); #1;
        check("ovr_at_valid overrun count", 64'(n_ovr - o0), 64'd1);
        check("ovr_at_valid valid count", 64'(n_valid - v0), 64'd1);
        v0 = n_valid;
        bus.in_data = {4{16'h2000}};
        bus.in_signed = '1;
        bus.gain = 16'h8888;
        bus.mute = 1'b0;
        bus.ce_sample = 1'b1;
        @(posedge clk); #1;
        bus.ce_sample = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        xp = 0;
        yp = 0;
        @(negedge clk);
        check_idle_outputs("mid_reset");
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (10) @(posedge clk); #1;
        check("mid_reset no valid", 64'(n_valid - v0), 64'd0);
        run_mix({16'h0000, 16'h0000, 16'h8000, 16'h1000}, 4'b1101, 16'h8888, 1'b0, 0, "after_reset");
        for (int i = 0; i < 20; i++) begin
            run_mix({$urandom, $urandom}, NCH'($urandom), (NCH*GW)'($urandom), ($urandom % 5) == 0, 0, "random");
        end
`ifdef AUDIO_MIXER_DC_BLOCK_EN
        rst = 1'b1;
        xp = 0;
        yp = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_mix({16'h0000, 16'h0000, 16'h0000, 16'h4000}, 4'b1111, 16'h8888, 1'b0, 0, "dc_step");
        check("dc_step first output", 64'(last_y), 64'h4000);
        for (int i = 1; i < 8192; i++) begin
            run_mix({16'h0000, 16'h0000, 16'h0000, 16'h4000}, 4'b1111, 16'h8888, 1'b0, 0, "dc_decay");
        end
        check("dc_decay settled", 64'($signed(last_y) < 16'sh0400 && $signed(last_y) >= 0), 64'd1);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
